// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the elastic pipeline stage.
//   state_t          - occupancy state of the stage (EMPTY / ONE / TWO)
//   DEFAULT_CTRL_W   - default control width
//   DEFAULT_CTRL_NOP - control value shown while no valid beat is held
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int DEFAULT_CTRL_W = 32;
    localparam logic [DEFAULT_CTRL_W-1:0] DEFAULT_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot
// One {valid, ctrl, data} holding register of the pipeline stage.
// Ports:
//   clk, rst             - clock, synchronous active-low reset
//   load                 - capture load_data/load_ctrl and mark valid
//   clear                - drop the valid bit (payload is kept)
//   load_data, load_ctrl - beat to capture
//   valid, data, ctrl    - held beat; ctrl reads as CTRL_NOP while not valid
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 128,
    parameter int                CTRL_W   = 32,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(DEFAULT_CTRL_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    // Clear beats load so a squash always wins over a same-cycle refill.
    // The payload is left untouched on clear: a bubble keeps the datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= CTRL_NOP;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
            ctrl_q  <= load_ctrl;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = valid_q ? ctrl_q : CTRL_NOP;

endmodule

// File: rtl/pipe_stage.sv
// pipe_stage
// Elastic pipeline stage with stall, flush and an optional skid slot.
// Ports:
//   clk, rst                     - clock, synchronous active-low reset
//   in_valid, in_ready           - upstream handshake
//   in_data, in_ctrl             - upstream beat
//   stall                        - hold the output beat (no issue)
//   flush                        - squash every held and arriving beat
//   out_valid, out_ready         - downstream handshake
//   out_data, out_ctrl           - held beat; out_ctrl is CTRL_NOP when idle
//   occ                          - number of held beats (0..2)
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 128,
    parameter int                CTRL_W   = 32,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(DEFAULT_CTRL_NOP),
    parameter bit                SKID_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occ
);

    state_t            state_q;
    state_t            state_d;
    logic              ready_q;
    logic              accept;
    logic              issue;
    logic              main_load;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_load_data;
    logic [CTRL_W-1:0] main_load_ctrl;

    assign accept = in_valid & in_ready;
    assign issue  = main_valid & out_ready & ~stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush overrides everything else; stall only suppresses issue, so an
    // accept while stalled in ONE still parks the new beat in the skid slot.
    always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (issue && accept) begin
                        main_load = 1'b1;
                    end else if (issue) begin
                        state_d    = EMPTY;
                        main_clear = 1'b1;
                    end else if (accept) begin
                        state_d   = TWO;
                        skid_load = 1'b1;
                    end
                end
                TWO: begin
                    if (issue) begin
                        state_d    = ONE;
                        main_load  = 1'b1;
                        skid_clear = 1'b1;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    // An occupied skid slot is always older than anything upstream.
    assign main_load_data = skid_valid ? skid_data : in_data;
    assign main_load_ctrl = skid_valid ? skid_ctrl : in_ctrl;

    // ready_q is 0 straight after reset; with the skid slot it also tracks
    // whether the next state leaves room for another beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_q <= 1'b0;
        end else if (SKID_EN) begin
            ready_q <= (state_d != TWO);
        end else begin
            ready_q <= 1'b1;
        end
    end

    pipe_slot #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CTRL_NOP(CTRL_NOP)
    ) u_main (
        .clk      (clk),
        .rst      (rst),
        .load     (main_load),
        .clear    (main_clear),
        .load_data(main_load_data),
        .load_ctrl(main_load_ctrl),
        .valid    (main_valid),
        .data     (out_data),
        .ctrl     (out_ctrl)
    );

    if (SKID_EN) begin : g_skid
        pipe_slot #(
            .DATA_W  (DATA_W),
            .CTRL_W  (CTRL_W),
            .CTRL_NOP(CTRL_NOP)
        ) u_skid (
            .clk      (clk),
            .rst      (rst),
            .load     (skid_load),
            .clear    (skid_clear),
            .load_data(in_data),
            .load_ctrl(in_ctrl),
            .valid    (skid_valid),
            .data     (skid_data),
            .ctrl     (skid_ctrl)
        );
        assign in_ready = ready_q;
    end else begin : g_no_skid
        logic unused_skid_ctl;
        assign unused_skid_ctl = skid_load ^ skid_clear;
        assign skid_valid      = 1'b0;
        assign skid_data       = '0;
        assign skid_ctrl       = '0;
        // Single register: a slot frees up in the same cycle it issues.
        assign in_ready        = ready_q & (~main_valid | issue);
    end

    assign out_valid = main_valid;
    assign occ       = state_q;

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage
// Scoreboard bench for pipe_stage. Index 0 is a SKID_EN=1 instance, index 1
// a SKID_EN=0 instance. Accepted beats are pushed onto a per-instance
// expected queue; a monitor on the falling edge compares the DUT outputs
// against the queue head and pops it whenever the beat issues.
module tb_pipe_stage;
    import pipe_pkg::*;

    localparam int DW = 128;
    localparam int CW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } beat_t;
    typedef beat_t beat_q_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [DW-1:0] in_data   [2];
    logic [CW-1:0] in_ctrl   [2];
    logic          stall     [2];
    logic          flush     [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [DW-1:0] out_data  [2];
    logic [CW-1:0] out_ctrl  [2];
    logic [1:0]    occ       [2];

    beat_q_t       sbq [2];
    beat_q_t       src [2];
    logic [DW-1:0] last_data [2];
    bit            src_en    [2];
    int            issued    [2];
    bit            after_reset = 1'b1;
    bit            model_live  = 1'b0;
    bit            cap_rst     = 1'b0;
    bit            cap_flush [2];
    bit            cap_acc   [2];
    bit            cap_iss   [2];
    beat_t         cap_beat  [2];

    int pass_cnt  = 0;
    int check_cnt = 0;

    pipe_stage #(
        .DATA_W(DW), .CTRL_W(CW), .CTRL_NOP('0), .SKID_EN(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
        .stall(stall[0]), .flush(flush[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_ctrl(out_ctrl[0]), .occ(occ[0])
    );

    pipe_stage #(
        .DATA_W(DW), .CTRL_W(CW), .CTRL_NOP('0), .SKID_EN(1'b0)
    ) dut_noskid (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
        .stall(stall[1]), .flush(flush[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_ctrl(out_ctrl[1]), .occ(occ[1])
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input int k, input logic [CW-1:0] ctrl,
                                 input logic [DW-1:0] data);
        beat_t b;
        b.data = data;
        b.ctrl = ctrl;
        src[k].push_back(b);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain(input int k, input int bound, output int cycles);
        cycles = 0;
        while ((sbq[k].size() > 0 || src[k].size() > 0) && cycles < bound) begin
            step(1);
            cycles++;
        end
        checkOutput($sformatf("drain%0d_left", k),
                    DW'(sbq[k].size() + src[k].size()), '0);
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: compare outputs with the expected queue, then sample the
    // handshakes that the coming rising edge will act on.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int    sz;
            bit    mdl_iss;
            bit    exp_rdy;
            beat_t head;
            sz      = sbq[k].size();
            mdl_iss = (sz > 0) && out_ready[k] && !stall[k];
            if (model_live) begin
                checkOutput($sformatf("occ%0d", k), DW'(occ[k]), DW'(sz));
                checkOutput($sformatf("out_valid%0d", k), DW'(out_valid[k]), DW'(sz > 0));
                if (sz > 0) begin
                    head = sbq[k][0];
                    checkOutput($sformatf("out_ctrl%0d", k), DW'(out_ctrl[k]), DW'(head.ctrl));
                    checkOutput($sformatf("out_data%0d", k), out_data[k], head.data);
                end else begin
                    checkOutput($sformatf("nop_ctrl%0d", k), DW'(out_ctrl[k]), '0);
                    checkOutput($sformatf("bubble_data%0d", k), out_data[k], last_data[k]);
                end
                if (after_reset) exp_rdy = 1'b0;
                else if (k == 0) exp_rdy = (sz < 2);
                else exp_rdy = (sz == 0) || mdl_iss;
                checkOutput($sformatf("in_ready%0d", k), DW'(in_ready[k]), DW'(exp_rdy));
                if (k == 1) checkOutput("noskid_occ_max", DW'(occ[1] <= 2'd1), DW'(1));
            end
            cap_acc[k]   = in_valid[k] && in_ready[k];
            cap_iss[k]   = mdl_iss;
            cap_flush[k] = flush[k];
            cap_beat[k]  = {in_data[k], in_ctrl[k]};
        end
        cap_rst = rst;
    end

    // Reference model: a FIFO of accepted beats, emptied by reset or flush.
    initial forever begin
        @(posedge clk);
        if (!cap_rst) begin
            for (int k = 0; k < 2; k++) begin
                sbq[k].delete();
                last_data[k] = '0;
            end
            after_reset = 1'b1;
            model_live  = 1'b1;
        end else begin
            after_reset = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (cap_flush[k]) begin
                    sbq[k].delete();
                end else begin
                    if (cap_iss[k]) begin
                        void'(sbq[k].pop_front());
                        issued[k]++;
                    end
                    if (cap_acc[k]) sbq[k].push_back(cap_beat[k]);
                end
                if (sbq[k].size() > 0) last_data[k] = sbq[k][0].data;
            end
        end
    end

    // Upstream source: hold the front beat until the stage accepts it.
    initial forever begin
        @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            if (cap_acc[k] && src[k].size() > 0) void'(src[k].pop_front());
            if (src_en[k] && src[k].size() > 0) begin
                in_valid[k] = 1'b1;
                {in_data[k], in_ctrl[k]} = src[k][0];
            end else begin
                in_valid[k] = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        int base;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_data[k] = '0; in_ctrl[k] = '0;
            stall[k] = 1'b0; flush[k] = 1'b0; out_ready[k] = 1'b0;
            src_en[k] = 1'b1; issued[k] = 0;
        end
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);

        // Streaming: 8 beats back to back, one cycle latency.
        out_ready[0] = 1'b1;
        base = issued[0];
        for (int i = 1; i <= 8; i++) applyStimulus(0, CW'(i), rand_data());
        waitDrain(0, 50, cyc);
        checkOutput("stream_cycles", DW'(cyc), DW'(9));
        checkOutput("stream_issued", DW'(issued[0] - base), DW'(8));

        // Backpressure: A out, B in skid, C held upstream.
        out_ready[0] = 1'b0;
        applyStimulus(0, 32'hA, rand_data());
        applyStimulus(0, 32'hB, rand_data());
        applyStimulus(0, 32'hC, rand_data());
        step(4);
        checkOutput("bp_occ", DW'(occ[0]), DW'(2));
        checkOutput("bp_in_ready", DW'(in_ready[0]), DW'(0));
        checkOutput("bp_c_held", DW'(in_valid[0]), DW'(1));
        out_ready[0] = 1'b1;
        waitDrain(0, 50, cyc);
        checkOutput("bp_cycles", DW'(cyc), DW'(3));

        // Stall: D held for 3 cycles while E fills the skid slot.
        stall[0] = 1'b1;
        applyStimulus(0, 32'hD, rand_data());
        applyStimulus(0, 32'hE, rand_data());
        step(1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_ctrl", DW'(out_ctrl[0]), DW'(32'hD));
            step(1);
        end
        checkOutput("stall_occ", DW'(occ[0]), DW'(2));
        stall[0] = 1'b0;
        waitDrain(0, 50, cyc);
        checkOutput("stall_cycles", DW'(cyc), DW'(2));

        // Flush with both slots full.
        out_ready[0] = 1'b0;
        applyStimulus(0, 32'h61, rand_data());
        applyStimulus(0, 32'h62, rand_data());
        step(2);
        flush[0] = 1'b1;
        step(1);
        flush[0] = 1'b0;
        checkOutput("flush2_occ", DW'(occ[0]), DW'(0));
        checkOutput("flush2_valid", DW'(out_valid[0]), DW'(0));
        checkOutput("flush2_ctrl", DW'(out_ctrl[0]), '0);
        checkOutput("flush2_ready", DW'(in_ready[0]), DW'(1));

        // Flush while beat F is being accepted: F must be discarded.
        applyStimulus(0, 32'h71, rand_data());
        step(1);
        base = issued[0];
        applyStimulus(0, 32'hF, rand_data());
        flush[0] = 1'b1;
        step(1);
        flush[0] = 1'b0;
        checkOutput("flushf_occ", DW'(occ[0]), DW'(0));
        checkOutput("flushf_ready", DW'(in_ready[0]), DW'(1));
        out_ready[0] = 1'b1;
        step(3);
        checkOutput("flushf_issued", DW'(issued[0] - base), DW'(0));

        // Single-register instance with out_ready toggling.
        base = issued[1];
        for (int i = 1; i <= 8; i++) applyStimulus(1, CW'(32'h100 + i), rand_data());
        for (int i = 0; i < 20; i++) begin
            out_ready[1] = (i % 2 == 0);
            step(1);
        end
        out_ready[1] = 1'b1;
        waitDrain(1, 50, cyc);
        checkOutput("noskid_issued", DW'(issued[1] - base), DW'(8));

        // Reset mid-stream with both slots full and flush raised.
        out_ready[0] = 1'b0;
        applyStimulus(0, 32'h81, rand_data());
        applyStimulus(0, 32'h82, rand_data());
        step(2);
        src[0].delete();
        src_en[0] = 1'b0;
        rst = 1'b0;
        flush[0] = 1'b1;
        step(1);
        rst = 1'b1;
        flush[0] = 1'b0;
        checkOutput("rst_occ", DW'(occ[0]), DW'(0));
        checkOutput("rst_data", out_data[0], '0);
        checkOutput("rst_ctrl", DW'(out_ctrl[0]), '0);
        checkOutput("rst_ready_low", DW'(in_ready[0]), DW'(0));
        step(1);
        checkOutput("rst_ready_high", DW'(in_ready[0]), DW'(1));
        src_en[0] = 1'b1;

        // Randomized traffic on both instances.
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < 2; k++) begin
                out_ready[k] = ($urandom_range(0, 3) != 0);
                stall[k]     = ($urandom_range(0, 7) == 0);
                flush[k]     = ($urandom_range(0, 39) == 0);
                src_en[k]    = ($urandom_range(0, 3) != 0);
                if (src[k].size() < 4) applyStimulus(k, $urandom, rand_data());
            end
            step(1);
        end
        for (int k = 0; k < 2; k++) begin
            out_ready[k] = 1'b1; stall[k] = 1'b0; flush[k] = 1'b0; src_en[k] = 1'b1;
        end
        waitDrain(0, 100, cyc);
        waitDrain(1, 100, cyc);
        step(2);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
